mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage access controller that consumes the EX/MEM pipeline register outputs and drives the data-cache request interface. It issues the load/store/LL/SC request, stalls the pipeline until the cache responds, and holds the result until the pipeline advances. It also owns the LL/SC link register, including snoop invalidation, and the sticky halt indication passed to writeback.

## Interface
Parameters:
- ADDR_W, 32: data address width.
- DATA_W, 32: data word width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- mem_read_in  in  1  EX/MEM M_MemRead output.
- mem_write_in  in  1  EX/MEM M_MemWrite output.
- datomic_in  in  1  EX/MEM datomic output; with read = LL, with write = SC.
- halt_in  in  1  EX/MEM halt output.
- addr_in  in  ADDR_W  EX/MEM alu_output (effective address).
- wdata_in  in  DATA_W  EX/MEM store data.
- pipe_adv  in  1  EX/MEM register loads a new instruction this edge (WEN & ~flush).
- dhit  in  1  cache completes the current request this cycle.
- dload  in  DATA_W  cache read data, valid when dhit.
- snoop_inv  in  1  another cache invalidates snoop_addr.
- snoop_addr  in  ADDR_W  invalidated address.
- dREN  out  1  read request.
- dWEN  out  1  write request.
- daddr  out  ADDR_W  request address, equal to addr_in.
- dstore  out  DATA_W  store data, equal to wdata_in.
- mem_stall  out  1  hold all upstream pipeline registers.
- mem_rdata  out  DATA_W  load data, or SC result {31'b0, ok}, for MEM/WB.
- halt_out  out  1  sticky halt to MEM/WB.

## Operation
- FSM states: IDLE, WAIT, DONE, HALT. Reset gives IDLE, link_valid=0, link_addr=0, rdata_q=0, sc_ok_q=0, halt_out=0.
- op = (mem_read_in | mem_write_in) & ~halted.
- sc_fail = datomic_in & mem_write_in & ~(link_valid & link_addr==addr_in).
- dREN = op & mem_read_in in IDLE/WAIT.
- dWEN = op & mem_write_in & ~sc_fail in IDLE/WAIT.
- In DONE and HALT, dREN and dWEN are 0.
- mem_stall = (dREN | dWEN) & ~dhit.
- IDLE: if no request, stay. If request & dhit: capture the result; go to DONE, or stay in IDLE if pipe_adv. If request & ~dhit: go to WAIT.
- IDLE with an SC that fails: no request and no stall. sc_ok_q=0. Go to DONE (or IDLE if pipe_adv).
- WAIT: on dhit, capture the result, then go to DONE (IDLE if pipe_adv). If op drops (flush), return to IDLE with no capture and no link change.
- DONE: on pipe_adv go to IDLE; otherwise hold. This prevents re-issue while the pipeline stalls for another reason.
- Capture on a load: rdata_q=dload.
- Capture on LL: link_valid=1, link_addr=addr_in.
- Capture on SC success: sc_ok_q=1, link_valid=0.
- Capture on a plain store with addr_in==link_addr: link_valid=0.
- mem_rdata:
  - In DONE: rdata_q, or {31'b0, sc_ok_q} for SC.
  - In IDLE/WAIT: dload, or {31'b0, sc_ok} for SC.
- snoop_inv with snoop_addr==link_addr clears link_valid. If it arrives in the same cycle as an LL capture, the LL wins. If it arrives in the same cycle as SC completion, the SC keeps its decided outcome.
- Halt: halt_in & ~mem_stall sets halt_out=1 and moves to HALT. HALT is left only by reset, and all requests are suppressed there.
- Reset mid-WAIT: requests drop asynchronously and the link is cleared.

## Timing
- Request is combinational from EX/MEM outputs in the same cycle the instruction arrives.
- Zero-wait hit: dhit in the same cycle gives mem_stall=0, and the pipeline advances that edge.
- N-cycle miss: mem_stall is high for N cycles, with daddr/dstore stable.
- The link register updates on the capturing edge, so an SC in the very next instruction sees the link.
- halt_out is asserted the edge after halt_in is accepted.

## Test plan
- LW addr 0x100, dhit after 3 cycles, dload 0xDEADBEEF: dREN high for 3 cycles with mem_stall=1, then 0; mem_rdata=0xDEADBEEF at the capturing edge.
- SW 0x200 data 0x12345678, dhit same cycle: dWEN for 1 cycle, mem_stall never asserted, no DONE hold when pipe_adv=1.
- LL 0x300 then SC 0x300 with dhit: link_valid set, SC issues dWEN, mem_rdata=1, link cleared. A second SC gives 0 with no dWEN and no stall.
- LL 0x300, then snoop_inv at 0x300, then SC 0x300: SC fails, mem_rdata=0, no dWEN. A snoop at 0x304 leaves the SC succeeding.
- LW completes while pipe_adv=0 for 4 cycles: DONE holds, dREN stays 0, mem_rdata holds the value; return to IDLE on pipe_adv.
- halt_in after a pending store: halt_out rises only after dhit, then dREN/dWEN stay 0. Asserting nRST mid-WAIT clears all outputs immediately.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-cache request/response bus plus snoop invalidation seen by the memory stage.
// master = memory-stage controller, slave = data cache.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dhit;
  logic [DATA_W-1:0] dload;
  logic              snoop_inv;
  logic [ADDR_W-1:0] snoop_addr;

  modport master (
    output dREN, dWEN, daddr, dstore,
    input  dhit, dload, snoop_inv, snoop_addr
  );

  modport slave (
    input  dREN, dWEN, daddr, dstore,
    output dhit, dload, snoop_inv, snoop_addr
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: issues load/store/LL/SC to the data cache, stalls until dhit,
// holds the result until the pipeline advances, owns the LL/SC link register and the sticky halt.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic               datomic_in,
  input  logic               halt_in,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic [DATA_W-1:0]  wdata_in,
  input  logic               pipe_adv,
  mem_access_unit_if.master  dcif,
  output logic               mem_stall,
  output logic [DATA_W-1:0]  mem_rdata,
  output logic               halt_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              link_valid_q, link_valid_d;
  logic [ADDR_W-1:0] link_addr_q, link_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              sc_ok_q, sc_ok_d;
  logic              halt_q, halt_d;

  logic is_ll, is_sc, halted, op, link_hit;
  logic sc_ok, sc_fail, active, ren, wen, stall, capture, snoop_hit;

  assign is_ll     = datomic_in & mem_read_in;
  assign is_sc     = datomic_in & mem_write_in;
  assign halted    = (state_q == HALT);
  assign op        = (mem_read_in | mem_write_in) & ~halted;
  assign link_hit  = link_valid_q & (link_addr_q == addr_in);
  assign sc_ok     = is_sc & link_hit;
  assign sc_fail   = is_sc & ~link_hit;
  assign active    = (state_q == IDLE) | (state_q == WAIT);
  assign snoop_hit = dcif.snoop_inv & (dcif.snoop_addr == link_addr_q);

  // Requests are gated by nRST so an asserted reset drops them without waiting for a clock.
  assign ren   = nRST & active & op & mem_read_in;
  assign wen   = nRST & active & op & mem_write_in & ~sc_fail;
  assign stall = (ren | wen) & ~dcif.dhit;

  // A failing SC completes locally: it never reaches the cache but still produces a result.
  assign capture = active & op & (((ren | wen) & dcif.dhit) | sc_fail);

  assign dcif.dREN   = ren;
  assign dcif.dWEN   = wen;
  assign dcif.daddr  = addr_in;
  assign dcif.dstore = wdata_in;
  assign mem_stall   = stall;
  assign halt_out    = halt_q;

  always_comb begin
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    rdata_d      = rdata_q;
    sc_ok_d      = sc_ok_q;

    // Snoop is applied first so that a same-cycle LL capture overrides it.
    if (snoop_hit) begin
      link_valid_d = 1'b0;
    end

    if (capture) begin
      if (mem_read_in) begin
        rdata_d = dcif.dload;
      end
      if (is_ll) begin
        link_valid_d = 1'b1;
        link_addr_d  = addr_in;
      end else if (is_sc) begin
        sc_ok_d = sc_ok;
        if (sc_ok) begin
          link_valid_d = 1'b0;
        end
      end else if (mem_write_in && (addr_in == link_addr_q)) begin
        link_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;

    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = pipe_adv ? IDLE : DONE;
        end else if (stall) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!op) begin
          state_d = IDLE;
        end else if (capture) begin
          state_d = pipe_adv ? IDLE : DONE;
        end
      end
      // Holding here keeps a completed access from re-issuing while another stage stalls.
      DONE: begin
        if (pipe_adv) begin
          state_d = IDLE;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase

    if (!halted && halt_in && !stall) begin
      state_d = HALT;
      halt_d  = 1'b1;
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (nRST) begin
      if (active) begin
        mem_rdata = is_sc ? {{(DATA_W-1){1'b0}}, sc_ok} : dcif.dload;
      end else begin
        mem_rdata = is_sc ? {{(DATA_W-1){1'b0}}, sc_ok_q} : rdata_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
      rdata_q      <= '0;
      sc_ok_q      <= 1'b0;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      rdata_q      <= rdata_d;
      sc_ok_q      <= sc_ok_d;
      halt_q       <= halt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected retirements are queued at issue and
// checked by an independent monitor whenever an instruction leaves the memory stage.
module tb_mem_access_unit;

  logic        CLK;
  logic        nRST;
  logic        mem_read_in, mem_write_in, datomic_in, halt_in, pipe_adv;
  logic [31:0] addr_in, wdata_in;
  logic        mem_stall, halt_out;
  logic [31:0] mem_rdata;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) dcif ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .datomic_in   (datomic_in),
    .halt_in      (halt_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .pipe_adv     (pipe_adv),
    .dcif         (dcif),
    .mem_stall    (mem_stall),
    .mem_rdata    (mem_rdata),
    .halt_out     (halt_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        dren;
    logic        dwen;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   failed = 0;
  int   stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_ret(input string n, input logic [31:0] rd, input logic ren,
                            input logic wen, input int st);
    exp_t e;
    e.name = n; e.rdata = rd; e.dren = ren; e.dwen = wen; e.stalls = st;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic at, input logic hlt,
                       input logic adv, input logic hit, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] ld);
    mem_read_in = rd; mem_write_in = wr; datomic_in = at; halt_in = hlt;
    pipe_adv = adv; dcif.dhit = hit; addr_in = a; wdata_in = wd; dcif.dload = ld;
  endtask

  task automatic snoop(input logic v, input logic [31:0] a);
    dcif.snoop_inv = v; dcif.snoop_addr = a;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: an instruction retires when the pipeline advances past a non-stalled memory op.
  always @(negedge CLK) begin
    if (!nRST) begin
      stall_cnt = 0;
    end else begin
      if (mem_stall) stall_cnt++;
      if (pipe_adv && !mem_stall && (mem_read_in || mem_write_in) && !halt_out) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL retire_unexpected: addr 0x%08h retired with no expected entry", addr_in);
        end else begin
          mon_e = exp_q.pop_front();
          chk({mon_e.name, "/rdata"}, mem_rdata, mon_e.rdata);
          chk({mon_e.name, "/dREN"}, 32'(dcif.dREN), 32'(mon_e.dren));
          chk({mon_e.name, "/dWEN"}, 32'(dcif.dWEN), 32'(mon_e.dwen));
          chk({mon_e.name, "/stalls"}, 32'(stall_cnt), 32'(mon_e.stalls));
        end
        stall_cnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 1'b0;
    snoop(1'b0, 32'h0);
    drive(1, 0, 0, 0, 0, 0, 32'h100, 32'h0, 32'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_dREN", 32'(dcif.dREN), 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_halt", 32'(halt_out), 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    nRST = 1'b1;
    step();

    // LW 0x100, three miss cycles then hit
    expect_ret("lw_miss", 32'hDEADBEEF, 1, 0, 3);
    drive(1, 0, 0, 0, 0, 0, 32'h100, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("lw_miss_dREN", 32'(dcif.dREN), 32'h1);
      chk("lw_miss_daddr", dcif.daddr, 32'h100);
      step();
    end
    drive(1, 0, 0, 0, 1, 1, 32'h100, 32'h0, 32'hDEADBEEF);
    step();

    // SW 0x200 zero-wait hit
    expect_ret("sw_hit", 32'h0, 0, 1, 0);
    drive(0, 1, 0, 0, 1, 1, 32'h200, 32'h12345678, 32'h0);
    @(negedge CLK);
    chk("sw_dstore", dcif.dstore, 32'h12345678);
    step();

    // LL then SC success, then a second SC fails
    expect_ret("ll_300", 32'hAAAA0001, 1, 0, 0);
    drive(1, 0, 1, 0, 1, 1, 32'h300, 32'h0, 32'hAAAA0001);
    step();
    expect_ret("sc_ok", 32'h1, 0, 1, 0);
    drive(0, 1, 1, 0, 1, 1, 32'h300, 32'h5, 32'h0);
    step();
    expect_ret("sc_again", 32'h0, 0, 0, 0);
    drive(0, 1, 1, 0, 1, 0, 32'h300, 32'h6, 32'h0);
    step();

    // LL, snoop on the linked address, SC fails
    expect_ret("ll_snp", 32'hAAAA0002, 1, 0, 0);
    drive(1, 0, 1, 0, 1, 1, 32'h300, 32'h0, 32'hAAAA0002);
    step();
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    snoop(1'b1, 32'h300);
    step();
    snoop(1'b0, 32'h0);
    expect_ret("sc_snooped", 32'h0, 0, 0, 0);
    drive(0, 1, 1, 0, 1, 0, 32'h300, 32'h7, 32'h0);
    step();

    // LL, snoop on a different address, SC succeeds
    expect_ret("ll_snp304", 32'h3, 1, 0, 0);
    drive(1, 0, 1, 0, 1, 1, 32'h300, 32'h0, 32'h3);
    step();
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    snoop(1'b1, 32'h304);
    step();
    snoop(1'b0, 32'h0);
    expect_ret("sc_other_snoop", 32'h1, 0, 1, 0);
    drive(0, 1, 1, 0, 1, 1, 32'h300, 32'h8, 32'h0);
    step();

    // Snoop coinciding with an LL capture: the LL keeps the link
    expect_ret("ll_400a", 32'h11, 1, 0, 0);
    drive(1, 0, 1, 0, 1, 1, 32'h400, 32'h0, 32'h11);
    step();
    expect_ret("ll_400b", 32'h22, 1, 0, 0);
    drive(1, 0, 1, 0, 1, 1, 32'h400, 32'h0, 32'h22);
    snoop(1'b1, 32'h400);
    step();
    snoop(1'b0, 32'h0);
    expect_ret("sc_after_ll_snoop", 32'h1, 0, 1, 0);
    drive(0, 1, 1, 0, 1, 1, 32'h400, 32'h9, 32'h0);
    step();

    // Snoop coinciding with SC completion: SC keeps its success
    expect_ret("ll_500", 32'h55, 1, 0, 0);
    drive(1, 0, 1, 0, 1, 1, 32'h500, 32'h0, 32'h55);
    step();
    expect_ret("sc_snoop_same", 32'h1, 0, 1, 0);
    drive(0, 1, 1, 0, 1, 1, 32'h500, 32'hA, 32'h0);
    snoop(1'b1, 32'h500);
    step();
    snoop(1'b0, 32'h0);
    expect_ret("sc_500_again", 32'h0, 0, 0, 0);
    drive(0, 1, 1, 0, 1, 0, 32'h500, 32'hB, 32'h0);
    step();

    // LW completes while the pipeline is held: result held, no re-issue
    drive(1, 0, 0, 0, 0, 1, 32'h600, 32'h0, 32'hCAFEF00D);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 0, 32'h600, 32'h0, 32'h0BADBAD0);
      @(negedge CLK);
      chk("done_dREN", 32'(dcif.dREN), 32'h0);
      chk("done_rdata", mem_rdata, 32'hCAFEF00D);
      chk("done_stall", 32'(mem_stall), 32'h0);
      step();
    end
    expect_ret("lw_held", 32'hCAFEF00D, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 32'h600, 32'h0, 32'h0BADBAD0);
    step();
    expect_ret("lw_after_done", 32'h600D, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 1, 32'h604, 32'h0, 32'h600D);
    step();

    // Halt waits for the pending store, then suppresses all requests
    expect_ret("sw_halt", 32'h0, 0, 1, 2);
    drive(0, 1, 0, 1, 0, 0, 32'h700, 32'h77, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("halt_pending", 32'(halt_out), 32'h0);
      step();
    end
    drive(0, 1, 0, 1, 1, 1, 32'h700, 32'h77, 32'h0);
    step();
    drive(1, 0, 0, 0, 1, 0, 32'h704, 32'h0, 32'h0);
    @(negedge CLK);
    chk("halt_set", 32'(halt_out), 32'h1);
    chk("halt_dREN", 32'(dcif.dREN), 32'h0);
    chk("halt_stall", 32'(mem_stall), 32'h0);
    drive(0, 1, 0, 0, 1, 0, 32'h708, 32'h1, 32'h0);
    #1;
    chk("halt_dWEN", 32'(dcif.dWEN), 32'h0);
    step();

    // Reset out of HALT, set a link, then reset mid-WAIT
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    step();
    chk("post_rst_halt", 32'(halt_out), 32'h0);
    expect_ret("ll_900", 32'h99, 1, 0, 0);
    drive(1, 0, 1, 0, 1, 1, 32'h900, 32'h0, 32'h99);
    step();
    drive(1, 0, 0, 0, 0, 0, 32'h800, 32'h0, 32'h0);
    step();
    #2;
    nRST = 1'b0;
    #1;
    chk("rst_wait_dREN", 32'(dcif.dREN), 32'h0);
    chk("rst_wait_stall", 32'(mem_stall), 32'h0);
    chk("rst_wait_halt", 32'(halt_out), 32'h0);
    chk("rst_wait_rdata", mem_rdata, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    step();
    nRST = 1'b1;
    step();
    expect_ret("sc_after_rst", 32'h0, 0, 0, 0);
    drive(0, 1, 1, 0, 1, 0, 32'h900, 32'hC, 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    step();

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
